// File: rtl/game_frame_sequencer.sv
// game_frame_sequencer
//   Runs the frame loop of the falling-sand engine. Each frame launches one
//   cell-update pass and enforces a minimum frame period. It then copies the
//   RAM next-state buffer into the VRAM display buffer through a read/write
//   pipeline matched to the RAM read latency. Also handles run/pause,
//   single-step, VRAM clear, overrun flagging and a frame counter.
//
// Ports
//   clk_i, reset_n_i    clock, asynchronous active-low reset
//   run_i               level, free-running frames while high
//   step_i              pulse, one frame while paused (sampled only in IDLE)
//   clear_i             zero the whole VRAM (sampled only in IDLE)
//   update_start_o      one-cycle launch pulse to the cell-update engine
//   update_done_i       one-cycle completion pulse from the cell-update engine
//   ram_rd_address_o    next-state RAM read address
//   ram_rd_data_i       RAM data, RAM_RD_LATENCY cycles after its address
//   vram_wr_address_o   VRAM write address
//   vram_wr_data_o      VRAM write data
//   vram_wr_en_o        VRAM write enable
//   busy_o              high whenever the sequencer is not idle
//   frame_done_o        one-cycle pulse on the last copy write of a frame
//   overrun_o           sticky, an update finished after the frame period
//   frame_count_o       completed frames, wraps
module game_frame_sequencer #(
  parameter int ACTIVE_COLUMNS    = 640,
  parameter int ACTIVE_ROWS       = 480,
  parameter int ADDR_WIDTH        = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH        = 2,
  parameter int FRAME_TICKS       = 100000000,
  parameter int TICK_WIDTH        = $clog2(FRAME_TICKS+1),
  parameter int RAM_RD_LATENCY    = 1,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         run_i,
  input  logic                         step_i,
  input  logic                         clear_i,
  output logic                         update_start_o,
  input  logic                         update_done_i,
  output logic [ADDR_WIDTH-1:0]        ram_rd_address_o,
  input  logic [DATA_WIDTH-1:0]        ram_rd_data_i,
  output logic [ADDR_WIDTH-1:0]        vram_wr_address_o,
  output logic [DATA_WIDTH-1:0]        vram_wr_data_o,
  output logic                         vram_wr_en_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic                         overrun_o,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count_o
);

  localparam int N     = ACTIVE_COLUMNS * ACTIVE_ROWS;
  // The copy counter runs past N while the write pipeline drains.
  localparam int CNT_W = $clog2(N + RAM_RD_LATENCY + 1);

  localparam logic [CNT_W-1:0]      CNT_N     = CNT_W'(N);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(N - 1);
  localparam logic [TICK_WIDTH-1:0] TICK_MAX  = TICK_WIDTH'(FRAME_TICKS);
  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(FRAME_TICKS - 1);
  localparam logic [TICK_WIDTH-1:0] TICK_ONE  = TICK_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPDATE,
    S_WAIT,
    S_COPY,
    S_CLEAR
  } state_t;

  state_t                  state_q, state_d;
  logic [TICK_WIDTH-1:0]   tick_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    step_frame_q;
  logic                    launch;
  logic                    set_overrun;
  logic                    rd_issue;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [RAM_RD_LATENCY-1:0] vld_p;
  logic [ADDR_WIDTH-1:0]   addr_p [RAM_RD_LATENCY];
  logic                    wr_vld;
  logic [ADDR_WIDTH-1:0]   wr_addr;

  // Copy read side: one read per cycle for the first N cycles of COPY.
  assign rd_issue = (state_q == S_COPY) && (cnt_q < CNT_N);
  assign rd_addr  = ADDR_WIDTH'(cnt_q);

  // Write side sits at the end of the latency-matched pipeline.
  assign wr_vld  = vld_p[RAM_RD_LATENCY-1];
  assign wr_addr = addr_p[RAM_RD_LATENCY-1];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    set_overrun = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_i) begin
          state_d = S_CLEAR;
        end else if (run_i || step_i) begin
          launch  = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (update_done_i) begin
          if (step_frame_q) begin
            state_d = S_COPY;
          end else if (tick_q >= TICK_LAST) begin
            // Update ran past the frame period: copy immediately, flag it.
            state_d     = S_COPY;
            set_overrun = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (tick_q >= TICK_LAST) begin
          state_d = S_COPY;
        end
      end
      S_COPY: begin
        if (wr_vld && (wr_addr == ADDR_LAST)) begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame timing and sweep counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tick_q        <= '0;
      cnt_q         <= '0;
      step_frame_q  <= 1'b0;
      overrun_o     <= 1'b0;
      frame_count_o <= '0;
    end else begin
      if (launch) begin
        tick_q       <= TICK_ONE;
        step_frame_q <= !run_i;
      end else if ((state_q == S_UPDATE || state_q == S_WAIT) && tick_q != TICK_MAX) begin
        tick_q <= tick_q + TICK_ONE;
      end
      // The sweep counter restarts from zero on every entry into COPY/CLEAR.
      if ((state_q == S_COPY || state_q == S_CLEAR) && state_d == state_q) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
      if (set_overrun) begin
        overrun_o <= 1'b1;
      end
      if (frame_done_o) begin
        frame_count_o <= frame_count_o + FRAME_COUNT_WIDTH'(1);
      end
    end
  end

  // Stage boundary: read issue -> write, RAM_RD_LATENCY registers deep.
  // The valid bits are reset so a copy in flight is dropped at once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_issue;
      for (int i = 1; i < RAM_RD_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    addr_p[0] <= rd_addr;
    for (int i = 1; i < RAM_RD_LATENCY; i++) begin
      addr_p[i] <= addr_p[i-1];
    end
  end

  // The launch decision is combinational in IDLE. Gating it with the reset
  // keeps the pulse low while reset is held even if run_i is already high.
  assign update_start_o   = launch && reset_n_i;
  assign busy_o           = (state_q != S_IDLE);
  assign ram_rd_address_o = rd_issue ? rd_addr : '0;
  assign frame_done_o     = wr_vld && (wr_addr == ADDR_LAST);
  assign vram_wr_en_o     = wr_vld || (state_q == S_CLEAR);
  assign vram_wr_data_o   = wr_vld ? ram_rd_data_i : '0;
  assign vram_wr_address_o = wr_vld               ? wr_addr :
                             (state_q == S_CLEAR) ? ADDR_WIDTH'(cnt_q) : '0;

endmodule

// File: tb/tb_game_frame_sequencer.sv
module tb_game_frame_sequencer;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int N    = COLS * ROWS;
  localparam int AW   = 3;
  localparam int DW   = 2;
  localparam int F    = 20;
  localparam int CW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, run, step, clr;
  logic          done    [2];
  logic          start   [2];
  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] rd_data [2];
  logic [AW-1:0] wr_addr [2];
  logic [DW-1:0] wr_data [2];
  logic          wr_en   [2];
  logic          busy    [2];
  logic          fd      [2];
  logic          ov      [2];
  logic [CW-1:0] fcnt    [2];

  game_frame_sequencer #(
    .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FRAME_TICKS(F), .TICK_WIDTH($clog2(F+1)), .RAM_RD_LATENCY(1), .FRAME_COUNT_WIDTH(CW)
  ) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .run_i(run), .step_i(step), .clear_i(clr),
    .update_start_o(start[0]), .update_done_i(done[0]),
    .ram_rd_address_o(rd_addr[0]), .ram_rd_data_i(rd_data[0]),
    .vram_wr_address_o(wr_addr[0]), .vram_wr_data_o(wr_data[0]), .vram_wr_en_o(wr_en[0]),
    .busy_o(busy[0]), .frame_done_o(fd[0]), .overrun_o(ov[0]), .frame_count_o(fcnt[0])
  );

  game_frame_sequencer #(
    .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FRAME_TICKS(F), .TICK_WIDTH($clog2(F+1)), .RAM_RD_LATENCY(3), .FRAME_COUNT_WIDTH(CW)
  ) dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .run_i(run), .step_i(step), .clear_i(clr),
    .update_start_o(start[1]), .update_done_i(done[1]),
    .ram_rd_address_o(rd_addr[1]), .ram_rd_data_i(rd_data[1]),
    .vram_wr_address_o(wr_addr[1]), .vram_wr_data_o(wr_data[1]), .vram_wr_en_o(wr_en[1]),
    .busy_o(busy[1]), .frame_done_o(fd[1]), .overrun_o(ov[1]), .frame_count_o(fcnt[1])
  );

  // Staged inputs, applied just after each rising edge
  logic s_rst_n = 1'b0, s_run = 1'b0, s_step = 1'b0, s_clr = 1'b0;
  int   dly = 5;           // cell-update duration for the next launch
  bit   spur_en = 1'b0;    // inject stray done pulses outside updates

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int lat [2] = '{1, 3};

  logic [DW-1:0] mem  [2][N];
  int            hist [2][4];

  // Reference model: per frame, the whole schedule is computed at launch
  int free_at [2], cs [2], cl_s [2], done_at [2], cnt_m [2];
  bit ovp [2], ov_m [2];

  // Per-scenario measurements
  int m_starts [2], m_launch [2], m_first_wr [2], m_writes [2], m_fd [2];

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 60)
        $display("FAIL %s (L=%0d) at cycle %0d: got %0d, expected %0d", name, lat[i], cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    free_at[i] = cyc + 1;
    cs[i]      = -1000;
    cl_s[i]    = -1000;
    done_at[i] = -1;
    cnt_m[i]   = 0;
    ov_m[i]    = 1'b0;
    ovp[i]     = 1'b0;
  endtask

  task automatic meas_clear();
    for (int i = 0; i < 2; i++) begin
      m_starts[i] = 0; m_launch[i] = -1; m_first_wr[i] = -1; m_writes[i] = 0; m_fd[i] = 0;
    end
  endtask

  task automatic model_check(input int i);
    int k, rd_e, we, wa, wd, fe, se, be;
    bit stepf;
    if (!rst_n) begin
      chk("reset start", i, int'(start[i]), 0);
      chk("reset wr_en", i, int'(wr_en[i]), 0);
      chk("reset wr_addr", i, int'(wr_addr[i]), 0);
      chk("reset wr_data", i, int'(wr_data[i]), 0);
      chk("reset rd_addr", i, int'(rd_addr[i]), 0);
      chk("reset busy", i, int'(busy[i]), 0);
      chk("reset frame_done", i, int'(fd[i]), 0);
      chk("reset overrun", i, int'(ov[i]), 0);
      chk("reset count", i, int'(fcnt[i]), 0);
      model_reset(i);
    end else begin
      be = (cyc < free_at[i]) ? 1 : 0;
      se = 0;
      if (be == 0) begin
        if (clr) begin
          cl_s[i]    = cyc + 1;
          free_at[i] = cyc + N + 1;
        end else if (run || step) begin
          se    = 1;
          stepf = !run;
          if (stepf || (dly + 1 > F)) cs[i] = cyc + dly + 1;
          else                        cs[i] = cyc + F;
          ovp[i]     = !stepf && (dly >= F - 1);
          free_at[i] = cs[i] + N + lat[i];
        end
      end
      if (cyc == cs[i] && ovp[i]) ov_m[i] = 1'b1;
      k    = cyc - cs[i];
      rd_e = (k >= 0 && k < N) ? k : 0;
      we = 0; wa = 0; wd = 0; fe = 0;
      k = cyc - cs[i] - lat[i];
      if (k >= 0 && k < N) begin
        we = 1; wa = k; wd = int'(mem[i][k]); fe = (k == N - 1) ? 1 : 0;
      end else begin
        k = cyc - cl_s[i];
        if (k >= 0 && k < N) begin
          we = 1; wa = k;
        end
      end
      chk("update_start", i, int'(start[i]), se);
      chk("busy", i, int'(busy[i]), be);
      chk("rd_addr", i, int'(rd_addr[i]), rd_e);
      chk("wr_en", i, int'(wr_en[i]), we);
      chk("wr_addr", i, int'(wr_addr[i]), wa);
      chk("wr_data", i, int'(wr_data[i]), wd);
      chk("frame_done", i, int'(fd[i]), fe);
      chk("overrun", i, int'(ov[i]), int'(ov_m[i]));
      chk("frame_count", i, int'(fcnt[i]), cnt_m[i]);
      if (fe != 0) cnt_m[i] = (cnt_m[i] + 1) % 65536;
      if (start[i]) done_at[i] = cyc + dly;
    end
    if (start[i]) begin
      m_starts[i]++;
      if (m_launch[i] < 0) m_launch[i] = cyc;
    end
    if (wr_en[i]) begin
      m_writes[i]++;
      if (m_first_wr[i] < 0) m_first_wr[i] = cyc;
    end
    if (fd[i]) m_fd[i]++;
    for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
    hist[i][0] = int'(rd_addr[i]);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = s_rst_n; run = s_run; step = s_step; clr = s_clr;
    for (int i = 0; i < 2; i++) begin
      done[i]    = (cyc == done_at[i]) ||
                   (spur_en && cyc > done_at[i] && $urandom_range(0, 19) == 0);
      rd_data[i] = mem[i][hist[i][lat[i]-1]];
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_check(i);
  endtask

  task automatic do_reset();
    s_rst_n = 1'b0; s_run = 1'b0; s_step = 1'b0; s_clr = 1'b0;
    cycle(); cycle();
    s_rst_n = 1'b1;
    cycle();
  endtask

  typedef struct {
    bit r; bit s; bit c; int d;
    int starts; int rd_off; int writes; int fds; int ovr;
  } vec_t;
  vec_t tbl [8];

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      done[i] = 1'b0; rd_data[i] = '0;
      for (int j = 0; j < 4; j++) hist[i][j] = 0;
      for (int k = 0; k < N; k++) mem[i][k] = DW'(k % 4);
      model_reset(i);
    end
    meas_clear();

    //          run step clr  d  starts rd_off writes fds ovr
    tbl[0] = '{1'b1, 1'b0, 1'b0,  5, 1, 20, 8, 1, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 25, 1, 26, 8, 1, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b0,  3, 1,  4, 8, 1, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 18, 1, 20, 8, 1, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 19, 1, 20, 8, 1, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 25, 1, 26, 8, 1, 0};
    tbl[6] = '{1'b1, 1'b1, 1'b0,  2, 1, 20, 8, 1, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b1,  5, 0,  0, 8, 0, 0};

    // Table-driven single-frame scenarios (inputs pulsed for one cycle)
    for (int t = 0; t < 8; t++) begin
      do_reset();
      meas_clear();
      dly = tbl[t].d;
      s_run = tbl[t].r; s_step = tbl[t].s; s_clr = tbl[t].c;
      cycle();
      s_run = 1'b0; s_step = 1'b0; s_clr = 1'b0;
      repeat (45) cycle();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("row%0d starts", t), i, m_starts[i], tbl[t].starts);
        chk($sformatf("row%0d writes", t), i, m_writes[i], tbl[t].writes);
        chk($sformatf("row%0d frame_done count", t), i, m_fd[i], tbl[t].fds);
        chk($sformatf("row%0d overrun", t), i, int'(ov[i]), tbl[t].ovr);
        chk($sformatf("row%0d frame_count", t), i, int'(fcnt[i]), tbl[t].fds);
        chk($sformatf("row%0d busy at end", t), i, int'(busy[i]), 0);
        if (tbl[t].starts > 0)
          chk($sformatf("row%0d first write offset", t), i,
              m_first_wr[i] - m_launch[i], tbl[t].rd_off + lat[i]);
      end
    end

    // Clear with run held, then continuous frames
    do_reset();
    meas_clear();
    dly = 5; s_run = 1'b1; s_clr = 1'b1;
    cycle();
    s_clr = 1'b0;
    repeat (90) cycle();
    s_run = 1'b0;
    repeat (40) cycle();
    for (int i = 0; i < 2; i++) begin
      chk("clear+run frames", i, int'(fcnt[i]), m_fd[i]);
      chk("clear+run writes", i, m_writes[i], N * (m_fd[i] + 1));
    end

    // Overrun stays set across later frames
    do_reset();
    dly = 25; s_run = 1'b1;
    repeat (40) cycle();
    dly = 4;
    repeat (70) cycle();
    s_run = 1'b0;
    repeat (40) cycle();
    for (int i = 0; i < 2; i++) chk("sticky overrun", i, int'(ov[i]), 1);

    // Reset asserted in the cycle of copy write 4
    do_reset();
    dly = 5; s_run = 1'b1;
    begin
      int n = 0;
      while (!(wr_en[0] && wr_addr[0] == 3'd3) && n < 60) begin
        cycle(); n++;
      end
      chk("reach copy write 3", 0, (n < 60) ? 1 : 0, 1);
    end
    s_rst_n = 1'b0;
    cycle();
    chk("midcopy reset wr_en", 0, int'(wr_en[0]), 0);
    chk("midcopy reset busy", 0, int'(busy[0]), 0);
    s_rst_n = 1'b1;
    cycle();
    chk("relaunch after reset", 0, int'(start[0]), 1);
    repeat (40) cycle();
    s_run = 1'b0;
    repeat (40) cycle();

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < N; k++) mem[i][k] = DW'($urandom_range(0, 3));
    spur_en = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      dly = $urandom_range(1, 30);
      if ($urandom_range(0, 19) == 0) s_run = !s_run;
      s_step  = ($urandom_range(0, 29) == 0);
      s_clr   = ($urandom_range(0, 59) == 0);
      s_rst_n = ($urandom_range(0, 499) != 0);
      cycle();
    end
    spur_en = 1'b0;
    s_rst_n = 1'b1; s_run = 1'b0; s_step = 1'b0; s_clr = 1'b0;
    repeat (60) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_frame_sequencer.md
Name: game_frame_sequencer

Overview:
Parametrised frame-level sequencer for the falling-sand engine. Launches one cell-update pass per frame and enforces a programmable frame period. Copies the RAM next-state buffer into VRAM with a latency-matched read/write pipeline. Adds run/pause, single-step, VRAM clear, overrun detection and a frame counter. Sits between the cell-update engine, the RAM next-state buffer and the VRAM display buffer.

Parameters:
ACTIVE_COLUMNS, 640, grid width in cells
ACTIVE_ROWS, 480, grid height in cells
ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width
DATA_WIDTH, 2, bits per cell (material code)
FRAME_TICKS, 100000000, clk cycles from update launch to copy start (>= 2)
TICK_WIDTH, $clog2(FRAME_TICKS+1), tick counter width
RAM_RD_LATENCY, 1, RAM read latency in cycles (1..4)
FRAME_COUNT_WIDTH, 16, frame counter width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
run_i  in  1  level: 1 = free-running frames, 0 = paused
step_i  in  1  pulse: run exactly one frame while paused
clear_i  in  1  pulse/level: zero all of VRAM
update_start_o  out  1  one-cycle launch pulse to the cell-update engine
update_done_i  in  1  one-cycle completion pulse from the cell-update engine
ram_rd_address_o  out  ADDR_WIDTH  RAM read address
ram_rd_data_i  in  DATA_WIDTH  RAM read data, valid RAM_RD_LATENCY cycles after its address
vram_wr_address_o  out  ADDR_WIDTH  VRAM write address
vram_wr_data_o  out  DATA_WIDTH  VRAM write data
vram_wr_en_o  out  1  VRAM write enable
busy_o  out  1  1 whenever state != IDLE
frame_done_o  out  1  one-cycle pulse on the last copy write
overrun_o  out  1  sticky: update finished after FRAME_TICKS elapsed
frame_count_o  out  FRAME_COUNT_WIDTH  completed frames, wraps modulo 2^FRAME_COUNT_WIDTH

Behaviour:
- Reset (async, reset_n_i=0): state IDLE, every output and counter 0, overrun_o cleared. vram_wr_en_o drops immediately, including mid-copy. No partial write completes.
- N = ACTIVE_COLUMNS*ACTIVE_ROWS. States: IDLE, UPDATE, WAIT, COPY, CLEAR.
- IDLE priority: clear_i > run_i > step_i. clear_i goes to CLEAR. Otherwise run_i or step_i asserts update_start_o this cycle, sets tick=1, goes to UPDATE. step_i is ignored outside IDLE.
- UPDATE: tick increments, saturating at FRAME_TICKS. On update_done_i:
  - free-run frame, tick < FRAME_TICKS-1: go to WAIT.
  - free-run frame, tick >= FRAME_TICKS-1: go to COPY and set overrun_o.
  - step frame: go to COPY directly, skipping WAIT.
- Frame type is latched at launch. Changing run_i mid-frame does not alter the current frame.
- WAIT: tick increments. When tick == FRAME_TICKS-1, go to COPY. First copy read issues exactly FRAME_TICKS cycles after the update_start_o cycle.
- COPY: cycle k (0..N-1 from entry) drives ram_rd_address_o=k. Cycle k+RAM_RD_LATENCY drives vram_wr_en_o=1, vram_wr_address_o=k, vram_wr_data_o=ram_rd_data_i.
  - Exactly N writes, addresses 0..N-1, no write at address N.
  - Address and enable pipeline depth equals RAM_RD_LATENCY.
  - On the write to N-1: frame_done_o=1 and frame_count_o increments next cycle. Next state IDLE.
  - Total COPY duration: N+RAM_RD_LATENCY cycles.
- CLEAR: N consecutive cycles of vram_wr_en_o=1, address 0..N-1, data 0, then IDLE. No frame_done_o pulse, no count change.
- Outside COPY/CLEAR: vram_wr_en_o=0, vram_wr_data_o=0. ram_rd_address_o holds 0 outside COPY.
- overrun_o clears only on reset.
- update_done_i outside UPDATE is ignored.

Test Plan:
- Bench config for all cases: 4x2 grid (N=8), FRAME_TICKS=20, DATA_WIDTH=2.
- Case 1, reset then run_i=1, done pulsed 5 cycles after launch, RAM[k]=k%4, L=1 -> first read 20 cycles after update_start_o. Writes at addr 0..7 with data 0,1,2,3,0,1,2,3 on 8 consecutive cycles. frame_done_o once, frame_count_o=1, next update_start_o 1 cycle after return to IDLE.
- Case 2, same as case 1 with RAM_RD_LATENCY=3 -> each write trails its read address by exactly 3 cycles. 8 writes total, none at address 8.
- Case 3, run_i=1, done pulsed 25 cycles after launch -> COPY begins the cycle after done. overrun_o=1 and stays 1 across subsequent frames.
- Case 4, run_i=0 with step_i pulse, done after 3 cycles -> COPY starts the next cycle with no WAIT. Then IDLE, and no further update_start_o.
- Case 5, clear_i and run_i both high in IDLE -> 8 writes of 0 to addresses 0..7, no frame_done_o. Update launches afterwards.
- Case 6, reset_n_i low at copy write 4 -> vram_wr_en_o=0 in the same cycle, all outputs 0. After release with run_i=1, update_start_o fires again.
